// File: rtl/dec_stage_pkg.sv
// Shared types and constants for the RV32I/Zicsr decode stage.
package dec_stage_pkg;

   localparam int XLEN      = 32;
   localparam int PC_WIDTH  = 32;
   localparam int REG_NUM   = 32;
   localparam int RIDX      = $clog2(REG_NUM);
   localparam int ALU_FUN_W = 4;

   // Major opcodes handled by the decoder
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // ALU function codes presented to EX
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_ADD  = 4'd0;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_SUB  = 4'd1;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_SLL  = 4'd2;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_SLT  = 4'd3;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_SLTU = 4'd4;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_XOR  = 4'd5;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_SRL  = 4'd6;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_SRA  = 4'd7;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_OR   = 4'd8;
   localparam logic [ALU_FUN_W-1:0] ALU_FUN_AND  = 4'd9;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   typedef enum logic [1:0] {
      OP1_RS1  = 2'd0,
      OP1_PC   = 2'd1,
      OP1_ZERO = 2'd2,
      OP1_ZIMM = 2'd3
   } op1_sel_e;

   typedef enum logic [0:0] {
      OP2_IMM = 1'b0,
      OP2_RS2 = 1'b1
   } op2_sel_e;

   // Raw control decoded from the opcode, before operand muxing
   typedef struct packed {
      logic [ALU_FUN_W-1:0] alu_fun;
      imm_fmt_e             imm_fmt;
      op1_sel_e             op1_sel;
      op2_sel_e             op2_sel;
      logic                 rs1_en;
      logic                 rs2_en;
      logic                 rd_en;
      logic                 mem_rena;
      logic                 mem_wena;
      logic                 csr_en;
      logic                 fun3_en;
      logic                 illegal;
   } dec_ctrl_t;

   // Contents of the ID/EX register
   typedef struct packed {
      logic [PC_WIDTH-1:0]  pc;
      logic [XLEN-1:0]      op1;
      logic [XLEN-1:0]      op2;
      logic [XLEN-1:0]      imm;
      logic [ALU_FUN_W-1:0] alu_fun;
      logic [RIDX-1:0]      rd_idx;
      logic                 rd_en;
      logic                 mem_rena;
      logic                 mem_wena;
      logic [2:0]           fun3;
      logic                 csr_en;
      logic                 illegal;
   } id_ex_t;

   // Sign-extended immediate for each instruction format
   function automatic logic [XLEN-1:0] gen_imm(input logic [31:7] ins, input imm_fmt_e fmt);
      case (fmt)
         IMM_I:   gen_imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   gen_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   gen_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   gen_imm = {ins[31:12], 12'h000};
         IMM_J:   gen_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: gen_imm = {XLEN{1'b0}};
      endcase
   endfunction

   // ALU code from funct3; bit 30 picks SUB only for register ops, SRA for both
   function automatic logic [ALU_FUN_W-1:0] alu_decode(input logic [2:0] f3, input logic b30,
                                                        input logic is_reg);
      case (f3)
         3'b000:  alu_decode = (is_reg && b30) ? ALU_FUN_SUB : ALU_FUN_ADD;
         3'b001:  alu_decode = ALU_FUN_SLL;
         3'b010:  alu_decode = ALU_FUN_SLT;
         3'b011:  alu_decode = ALU_FUN_SLTU;
         3'b100:  alu_decode = ALU_FUN_XOR;
         3'b101:  alu_decode = b30 ? ALU_FUN_SRA : ALU_FUN_SRL;
         3'b110:  alu_decode = ALU_FUN_OR;
         3'b111:  alu_decode = ALU_FUN_AND;
         default: alu_decode = ALU_FUN_ADD;
      endcase
   endfunction

endpackage

// File: rtl/dec_stage_if.sv
// IF->ID request and ID->EX bundle of the decode stage.
interface dec_stage_if
   import dec_stage_pkg::*;
   ();

   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          instr_i;
   logic [PC_WIDTH-1:0]  pc_i;

   logic                 out_valid;
   logic                 out_ready;
   logic [PC_WIDTH-1:0]  out_pc;
   logic [XLEN-1:0]      out_op1;
   logic [XLEN-1:0]      out_op2;
   logic [XLEN-1:0]      out_imm;
   logic [ALU_FUN_W-1:0] out_alu_fun;
   logic [RIDX-1:0]      out_rd_idx;
   logic                 out_rd_en;
   logic                 out_mem_rena;
   logic                 out_mem_wena;
   logic [2:0]           out_fun3;
   logic                 out_csr_en;
   logic                 out_illegal;

   // Environment side: drives fetch requests and the EX ready
   modport master (
      output in_valid, instr_i, pc_i, out_ready,
      input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_alu_fun,
             out_rd_idx, out_rd_en, out_mem_rena, out_mem_wena, out_fun3, out_csr_en,
             out_illegal
   );

   // Decode stage side
   modport slave (
      input  in_valid, instr_i, pc_i, out_ready,
      output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm, out_alu_fun,
             out_rd_idx, out_rd_en, out_mem_rena, out_mem_wena, out_fun3, out_csr_en,
             out_illegal
   );

endinterface

// File: rtl/dec_stage_scoreboard.sv
// Pending-load scoreboard: one bit per register, two lookup ports.
module dec_scoreboard
   import dec_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_valid,
   input  logic [RIDX-1:0] set_idx,
   input  logic            clr_valid,
   input  logic [RIDX-1:0] clr_idx,
   input  logic [RIDX-1:0] rd_idx_a,
   input  logic [RIDX-1:0] rd_idx_b,
   output logic            hit_a,
   output logic            hit_b
);

   logic [REG_NUM-1:0] sb_r;
   logic [REG_NUM-1:0] sb_next_s;

   // Next state per bit: a set outranks a clear to the same index, x0 stays clean
   always_comb begin
      sb_next_s = sb_r;
      for (int i = 0; i < REG_NUM; i++) begin
         if (i == 0) begin
            sb_next_s[i] = 1'b0;
         end else begin
            sb_next_s[i] = (set_valid && (set_idx == RIDX'(i))) ? 1'b1 :
                           ((clr_valid && (clr_idx == RIDX'(i))) ? 1'b0 : sb_r[i]);
         end
      end
   end

   // Scoreboard register with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_r <= {REG_NUM{1'b0}};
      end else begin
         sb_r <= sb_next_s;
      end
   end

   assign hit_a = sb_r[rd_idx_a];
   assign hit_b = sb_r[rd_idx_b];

endmodule

// File: rtl/dec_stage.sv
// Registered RV32I/Zicsr decode stage with load-use stall and valid/ready handshakes.
module dec_stage
   import dec_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   dec_stage_if.slave      bus,
   output logic [RIDX-1:0] rs1_idx_o,
   output logic [RIDX-1:0] rs2_idx_o,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   input  logic            wb_clr_valid,
   input  logic [RIDX-1:0] wb_clr_idx
);

   logic [6:0]      opcode_s;
   logic [2:0]      f3_s;
   logic [RIDX-1:0] rd_s;
   logic [RIDX-1:0] rs1_s;
   logic [RIDX-1:0] rs2_s;
   dec_ctrl_t       ctrl_s;
   id_ex_t          bundle_s;
   id_ex_t          bundle_r;
   logic            out_valid_r;
   logic            rs1_use_s;
   logic            rs2_use_s;
   logic            sb_hit1_s;
   logic            sb_hit2_s;
   logic            ex_load_s;
   logic            hz_s;
   logic            in_ready_s;
   logic            accept_s;
   logic            sb_set_s;

   assign opcode_s  = bus.instr_i[6:0];
   assign f3_s      = bus.instr_i[14:12];
   assign rd_s      = bus.instr_i[11:7];
   assign rs1_s     = bus.instr_i[19:15];
   assign rs2_s     = bus.instr_i[24:20];
   assign rs1_idx_o = rs1_s;
   assign rs2_idx_o = rs2_s;

   // Opcode decode into raw control fields
   always_comb begin
      ctrl_s         = '0;
      ctrl_s.alu_fun = ALU_FUN_ADD;
      ctrl_s.imm_fmt = IMM_NONE;
      ctrl_s.op1_sel = OP1_RS1;
      ctrl_s.op2_sel = OP2_IMM;
      case (opcode_s)
         OPC_OP_IMM: begin
            ctrl_s.imm_fmt = IMM_I;
            ctrl_s.rs1_en  = 1'b1;
            ctrl_s.rd_en   = 1'b1;
            ctrl_s.fun3_en = 1'b1;
            ctrl_s.alu_fun = alu_decode(f3_s, bus.instr_i[30], 1'b0);
         end
         OPC_OP: begin
            ctrl_s.op2_sel = OP2_RS2;
            ctrl_s.rs1_en  = 1'b1;
            ctrl_s.rs2_en  = 1'b1;
            ctrl_s.rd_en   = 1'b1;
            ctrl_s.fun3_en = 1'b1;
            ctrl_s.alu_fun = alu_decode(f3_s, bus.instr_i[30], 1'b1);
         end
         OPC_BRANCH: begin
            ctrl_s.imm_fmt = IMM_B;
            ctrl_s.op2_sel = OP2_RS2;
            ctrl_s.rs1_en  = 1'b1;
            ctrl_s.rs2_en  = 1'b1;
            ctrl_s.fun3_en = 1'b1;
            ctrl_s.alu_fun = ALU_FUN_SUB;
         end
         OPC_JAL: begin
            ctrl_s.imm_fmt = IMM_J;
            ctrl_s.op1_sel = OP1_PC;
            ctrl_s.rd_en   = 1'b1;
         end
         OPC_JALR: begin
            ctrl_s.imm_fmt = IMM_I;
            ctrl_s.rs1_en  = 1'b1;
            ctrl_s.rd_en   = 1'b1;
            ctrl_s.fun3_en = 1'b1;
         end
         OPC_LUI: begin
            ctrl_s.imm_fmt = IMM_U;
            ctrl_s.op1_sel = OP1_ZERO;
            ctrl_s.rd_en   = 1'b1;
         end
         OPC_AUIPC: begin
            ctrl_s.imm_fmt = IMM_U;
            ctrl_s.op1_sel = OP1_PC;
            ctrl_s.rd_en   = 1'b1;
         end
         OPC_LOAD: begin
            ctrl_s.imm_fmt  = IMM_I;
            ctrl_s.rs1_en   = 1'b1;
            ctrl_s.rd_en    = 1'b1;
            ctrl_s.mem_rena = 1'b1;
            ctrl_s.fun3_en  = 1'b1;
         end
         OPC_STORE: begin
            ctrl_s.imm_fmt  = IMM_S;
            ctrl_s.rs1_en   = 1'b1;
            ctrl_s.rs2_en   = 1'b1;
            ctrl_s.mem_wena = 1'b1;
            ctrl_s.fun3_en  = 1'b1;
         end
         OPC_SYSTEM: begin
            // funct3==0 is ECALL/EBREAK: no CSR access and no register traffic
            ctrl_s.imm_fmt = IMM_I;
            ctrl_s.fun3_en = 1'b1;
            ctrl_s.csr_en  = (f3_s != 3'b000);
            ctrl_s.rd_en   = (f3_s != 3'b000);
            ctrl_s.rs1_en  = (f3_s != 3'b000) && !f3_s[2];
            ctrl_s.op1_sel = f3_s[2] ? OP1_ZIMM : OP1_RS1;
         end
         default: begin
            ctrl_s.illegal = 1'b1;
         end
      endcase
   end

   // Operand selection and assembly of the next ID/EX bundle
   always_comb begin
      bundle_s          = '0;
      bundle_s.pc       = bus.pc_i;
      bundle_s.imm      = gen_imm(bus.instr_i[31:7], ctrl_s.imm_fmt);
      case (ctrl_s.op1_sel)
         OP1_PC:   bundle_s.op1 = XLEN'(bus.pc_i);
         OP1_ZERO: bundle_s.op1 = {XLEN{1'b0}};
         OP1_ZIMM: bundle_s.op1 = {{(XLEN-5){1'b0}}, bus.instr_i[19:15]};
         default:  bundle_s.op1 = rs1_i;
      endcase
      bundle_s.op2      = (ctrl_s.op2_sel == OP2_RS2) ? rs2_i : bundle_s.imm;
      bundle_s.alu_fun  = ctrl_s.alu_fun;
      bundle_s.rd_en    = ctrl_s.rd_en && (rd_s != {RIDX{1'b0}});
      bundle_s.rd_idx   = bundle_s.rd_en ? rd_s : {RIDX{1'b0}};
      bundle_s.mem_rena = ctrl_s.mem_rena;
      bundle_s.mem_wena = ctrl_s.mem_wena;
      bundle_s.fun3     = ctrl_s.fun3_en ? f3_s : 3'b000;
      bundle_s.csr_en   = ctrl_s.csr_en;
      bundle_s.illegal  = ctrl_s.illegal;
   end

   // A source counts only if the instruction reads it and it is not x0
   assign rs1_use_s = ctrl_s.rs1_en && (rs1_s != {RIDX{1'b0}});
   assign rs2_use_s = ctrl_s.rs2_en && (rs2_s != {RIDX{1'b0}});

   // Load sitting in ID/EX has not reached the scoreboard yet
   assign ex_load_s = out_valid_r && bundle_r.mem_rena && bundle_r.rd_en;

   assign hz_s = (rs1_use_s && (sb_hit1_s || (ex_load_s && (bundle_r.rd_idx == rs1_s)))) ||
                 (rs2_use_s && (sb_hit2_s || (ex_load_s && (bundle_r.rd_idx == rs2_s))));

   assign in_ready_s = (!out_valid_r || bus.out_ready) && !hz_s;
   assign accept_s   = bus.in_valid && in_ready_s && !flush_i;
   assign sb_set_s   = out_valid_r && bus.out_ready && bundle_r.mem_rena && bundle_r.rd_en;

   dec_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_valid (sb_set_s),
      .set_idx   (bundle_r.rd_idx),
      .clr_valid (wb_clr_valid),
      .clr_idx   (wb_clr_idx),
      .rd_idx_a  (rs1_s),
      .rd_idx_b  (rs2_s),
      .hit_a     (sb_hit1_s),
      .hit_b     (sb_hit2_s)
   );

   // ID/EX register: flush kills, accept loads, EX ready drains, otherwise hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         bundle_r    <= '0;
      end else begin
         if (flush_i) begin
            out_valid_r <= 1'b0;
         end else if (accept_s) begin
            out_valid_r <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (accept_s) begin
            bundle_r <= bundle_s;
         end else begin
            bundle_r <= bundle_r;
         end
      end
   end

   assign bus.in_ready     = in_ready_s;
   assign bus.out_valid    = out_valid_r;
   assign bus.out_pc       = bundle_r.pc;
   assign bus.out_op1      = bundle_r.op1;
   assign bus.out_op2      = bundle_r.op2;
   assign bus.out_imm      = bundle_r.imm;
   assign bus.out_alu_fun  = bundle_r.alu_fun;
   assign bus.out_rd_idx   = bundle_r.rd_idx;
   assign bus.out_rd_en    = bundle_r.rd_en;
   assign bus.out_mem_rena = bundle_r.mem_rena;
   assign bus.out_mem_wena = bundle_r.mem_wena;
   assign bus.out_fun3     = bundle_r.fun3;
   assign bus.out_csr_en   = bundle_r.csr_en;
   assign bus.out_illegal  = bundle_r.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: decode vector table plus handshake/hazard sequences.
module tb_dec_stage;
   import dec_stage_pkg::*;

   logic            clk;
   logic            rst_n;
   logic [RIDX-1:0] rs1_idx_o;
   logic [RIDX-1:0] rs2_idx_o;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            wb_clr_valid;
   logic [RIDX-1:0] wb_clr_idx;

   int n_cmp;
   int n_err;

   dec_stage_if bus_if ();

   dec_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus_if),
      .rs1_idx_o    (rs1_idx_o),
      .rs2_idx_o    (rs2_idx_o),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .flush_i      (flush_i),
      .wb_clr_valid (wb_clr_valid),
      .wb_clr_idx   (wb_clr_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic [4:0]  rd;
      logic        rd_en;
      logic        rena;
      logic        wena;
      logic [2:0]  f3;
      logic        csr;
      logic        ill;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic add_vec(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
                          input logic [3:0] alu, input logic [4:0] rd, input logic rd_en,
                          input logic rena, input logic wena, input logic [2:0] f3,
                          input logic csr, input logic ill);
      vec_t v;
      v.name = nm; v.instr = ins; v.pc = pc; v.op1 = op1; v.op2 = op2; v.imm = imm;
      v.alu = alu; v.rd = rd; v.rd_en = rd_en; v.rena = rena; v.wena = wena;
      v.f3 = f3; v.csr = csr; v.ill = ill;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_if.in_valid = 1'b0;
      flush_i         = 1'b0;
      wb_clr_valid    = 1'b0;
      bus_if.out_ready = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      rs1_i = 32'h0000000A;
      rs2_i = 32'h00000033;
      flush_i = 1'b0;
      wb_clr_valid = 1'b0;
      wb_clr_idx = 5'd0;
      bus_if.in_valid = 1'b1;
      bus_if.instr_i = enc_i(12'h001, 5'd2, 3'b000, 5'd1, OPC_OP_IMM);
      bus_if.pc_i = 32'h00000100;
      bus_if.out_ready = 1'b1;

      // ---- reset with in_valid high
      tick();
      @(negedge clk);
      chk("rst_valid_0", bus_if.out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("rst_valid_1", bus_if.out_valid, 1'b0);
      chk("rst_op1", bus_if.out_op1, 32'h0);
      chk("rst_pc", bus_if.out_pc, 32'h0);
      chk("rst_rd_en", bus_if.out_rd_en, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus_if.in_ready, 1'b1);
      chk("rst_out_valid", bus_if.out_valid, 1'b0);
      tick();

      // ---- decode vector table
      add_vec("addi", enc_i(12'hFFB, 5'd2, 3'b000, 5'd1, OPC_OP_IMM), 32'h100,
              32'hA, 32'hFFFFFFFB, 32'hFFFFFFFB, ALU_FUN_ADD, 5'd1, 1, 0, 0, 3'd0, 0, 0);
      add_vec("srai", enc_i(12'h407, 5'd3, 3'b101, 5'd4, OPC_OP_IMM), 32'h100,
              32'hA, 32'h407, 32'h407, ALU_FUN_SRA, 5'd4, 1, 0, 0, 3'd5, 0, 0);
      add_vec("srli", enc_i(12'h007, 5'd3, 3'b101, 5'd4, OPC_OP_IMM), 32'h100,
              32'hA, 32'h7, 32'h7, ALU_FUN_SRL, 5'd4, 1, 0, 0, 3'd5, 0, 0);
      add_vec("sub", enc_r(7'b0100000, 5'd8, 5'd7, 3'b000, 5'd6, OPC_OP), 32'h100,
              32'hA, 32'h33, 32'h0, ALU_FUN_SUB, 5'd6, 1, 0, 0, 3'd0, 0, 0);
      add_vec("sra", enc_r(7'b0100000, 5'd8, 5'd7, 3'b101, 5'd6, OPC_OP), 32'h100,
              32'hA, 32'h33, 32'h0, ALU_FUN_SRA, 5'd6, 1, 0, 0, 3'd5, 0, 0);
      add_vec("lui", enc_u(20'h12345, 5'd9, OPC_LUI), 32'h100,
              32'h0, 32'h12345000, 32'h12345000, ALU_FUN_ADD, 5'd9, 1, 0, 0, 3'd0, 0, 0);
      add_vec("auipc", enc_u(20'h80000, 5'd10, OPC_AUIPC), 32'h100,
              32'h100, 32'h80000000, 32'h80000000, ALU_FUN_ADD, 5'd10, 1, 0, 0, 3'd0, 0, 0);
      add_vec("jal", enc_j(21'h1FFFFC, 5'd1), 32'h200,
              32'h200, 32'hFFFFFFFC, 32'hFFFFFFFC, ALU_FUN_ADD, 5'd1, 1, 0, 0, 3'd0, 0, 0);
      add_vec("beq", enc_b(13'h0008, 5'd2, 5'd1, 3'b000), 32'h100,
              32'hA, 32'h33, 32'h8, ALU_FUN_SUB, 5'd0, 0, 0, 0, 3'd0, 0, 0);
      add_vec("bne", enc_b(13'h1FF0, 5'd4, 5'd3, 3'b001), 32'h100,
              32'hA, 32'h33, 32'hFFFFFFF0, ALU_FUN_SUB, 5'd0, 0, 0, 0, 3'd1, 0, 0);
      add_vec("lw", enc_i(12'h00C, 5'd2, 3'b010, 5'd5, OPC_LOAD), 32'h100,
              32'hA, 32'hC, 32'hC, ALU_FUN_ADD, 5'd5, 1, 1, 0, 3'd2, 0, 0);
      add_vec("sw", enc_s(12'hFEC, 5'd8, 5'd2, 3'b010), 32'h100,
              32'hA, 32'hFFFFFFEC, 32'hFFFFFFEC, ALU_FUN_ADD, 5'd0, 0, 0, 1, 3'd2, 0, 0);
      add_vec("jalr", enc_i(12'h7FF, 5'd3, 3'b000, 5'd1, OPC_JALR), 32'h100,
              32'hA, 32'h7FF, 32'h7FF, ALU_FUN_ADD, 5'd1, 1, 0, 0, 3'd0, 0, 0);
      add_vec("csrrw", enc_i(12'h300, 5'd12, 3'b001, 5'd11, OPC_SYSTEM), 32'h100,
              32'hA, 32'h300, 32'h300, ALU_FUN_ADD, 5'd11, 1, 0, 0, 3'd1, 1, 0);
      add_vec("csrrsi", enc_i(12'h341, 5'd31, 3'b110, 5'd11, OPC_SYSTEM), 32'h100,
              32'h1F, 32'h341, 32'h341, ALU_FUN_ADD, 5'd11, 1, 0, 0, 3'd6, 1, 0);
      add_vec("illegal", 32'h123450FF, 32'h100,
              32'hA, 32'h0, 32'h0, ALU_FUN_ADD, 5'd0, 0, 0, 0, 3'd0, 0, 1);
      add_vec("lui_x0", enc_u(20'h00001, 5'd0, OPC_LUI), 32'h100,
              32'h0, 32'h1000, 32'h1000, ALU_FUN_ADD, 5'd0, 0, 0, 0, 3'd0, 0, 0);

      idle();
      foreach (vq[k]) begin
         bus_if.instr_i  = vq[k].instr;
         bus_if.pc_i     = vq[k].pc;
         bus_if.in_valid = 1'b1;
         @(negedge clk);
         chk({vq[k].name, "_in_ready"}, bus_if.in_ready, 1'b1);
         if (k == 0) chk("addi_rs1_idx", rs1_idx_o, 5'd2);
         tick();
         bus_if.in_valid = 1'b0;
         @(negedge clk);
         chk({vq[k].name, "_valid"}, bus_if.out_valid, 1'b1);
         chk({vq[k].name, "_pc"}, bus_if.out_pc, vq[k].pc);
         chk({vq[k].name, "_op1"}, bus_if.out_op1, vq[k].op1);
         chk({vq[k].name, "_op2"}, bus_if.out_op2, vq[k].op2);
         chk({vq[k].name, "_imm"}, bus_if.out_imm, vq[k].imm);
         chk({vq[k].name, "_alu"}, bus_if.out_alu_fun, vq[k].alu);
         chk({vq[k].name, "_rd"}, bus_if.out_rd_idx, vq[k].rd);
         chk({vq[k].name, "_rd_en"}, bus_if.out_rd_en, vq[k].rd_en);
         chk({vq[k].name, "_rena"}, bus_if.out_mem_rena, vq[k].rena);
         chk({vq[k].name, "_wena"}, bus_if.out_mem_wena, vq[k].wena);
         chk({vq[k].name, "_fun3"}, bus_if.out_fun3, vq[k].f3);
         chk({vq[k].name, "_csr"}, bus_if.out_csr_en, vq[k].csr);
         chk({vq[k].name, "_ill"}, bus_if.out_illegal, vq[k].ill);
         tick();
         wb_clr_valid = 1'b1;
         wb_clr_idx   = vq[k].rd;
         @(negedge clk);
         chk({vq[k].name, "_drained"}, bus_if.out_valid, 1'b0);
         tick();
         wb_clr_valid = 1'b0;
      end

      // ---- load-use stall: LW x5 then ADD x6,x5,x5
      bus_if.instr_i  = enc_i(12'h000, 5'd2, 3'b010, 5'd5, OPC_LOAD);
      bus_if.in_valid = 1'b1;
      @(negedge clk);
      chk("lu_lw_ready", bus_if.in_ready, 1'b1);
      tick();
      bus_if.instr_i = enc_r(7'b0000000, 5'd5, 5'd5, 3'b000, 5'd6, OPC_OP);
      @(negedge clk);
      chk("lu_lw_valid", bus_if.out_valid, 1'b1);
      chk("lu_stall_ex", bus_if.in_ready, 1'b0);
      tick();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("lu_stall_sb", bus_if.in_ready, 1'b0);
         chk("lu_bubble", bus_if.out_valid, 1'b0);
         tick();
      end
      wb_clr_valid = 1'b1;
      wb_clr_idx   = 5'd5;
      @(negedge clk);
      chk("lu_no_bypass", bus_if.in_ready, 1'b0);
      tick();
      wb_clr_valid = 1'b0;
      @(negedge clk);
      chk("lu_released", bus_if.in_ready, 1'b1);
      tick();
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk("lu_add_valid", bus_if.out_valid, 1'b1);
      chk("lu_add_rd", bus_if.out_rd_idx, 5'd6);
      tick();
      @(negedge clk);
      chk("lu_no_dup", bus_if.out_valid, 1'b0);
      tick();

      // ---- backpressure: out_ready low for 3 cycles
      bus_if.out_ready = 1'b0;
      bus_if.instr_i   = enc_i(12'h011, 5'd0, 3'b000, 5'd7, OPC_OP_IMM);
      bus_if.in_valid  = 1'b1;
      @(negedge clk);
      chk("bp_first_ready", bus_if.in_ready, 1'b1);
      tick();
      bus_if.instr_i = enc_i(12'h022, 5'd0, 3'b000, 5'd8, OPC_OP_IMM);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", bus_if.out_valid, 1'b1);
         chk("bp_hold_rd", bus_if.out_rd_idx, 5'd7);
         chk("bp_hold_op2", bus_if.out_op2, 32'h11);
         chk("bp_in_ready", bus_if.in_ready, 1'b0);
         tick();
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_ready", bus_if.in_ready, 1'b1);
      chk("bp_resume_rd", bus_if.out_rd_idx, 5'd7);
      tick();
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_valid", bus_if.out_valid, 1'b1);
      chk("bp_next_rd", bus_if.out_rd_idx, 5'd8);
      chk("bp_next_op2", bus_if.out_op2, 32'h22);
      tick();
      @(negedge clk);
      chk("bp_no_dup", bus_if.out_valid, 1'b0);
      tick();

      // ---- flush: scoreboard bit for x9 must survive
      bus_if.instr_i  = enc_i(12'h000, 5'd2, 3'b010, 5'd9, OPC_LOAD);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      tick();
      bus_if.instr_i  = enc_i(12'h011, 5'd0, 3'b000, 5'd7, OPC_OP_IMM);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.instr_i   = enc_i(12'h022, 5'd0, 3'b000, 5'd8, OPC_OP_IMM);
      flush_i          = 1'b1;
      bus_if.out_ready = 1'b0;
      @(negedge clk);
      chk("fl_pre_valid", bus_if.out_valid, 1'b1);
      tick();
      flush_i          = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      chk("fl_kill", bus_if.out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("fl_drop", bus_if.out_valid, 1'b0);
      bus_if.instr_i  = enc_r(7'b0000000, 5'd0, 5'd9, 3'b000, 5'd10, OPC_OP);
      bus_if.in_valid = 1'b1;
      #1;
      @(negedge clk);
      chk("fl_sb_kept", bus_if.in_ready, 1'b0);
      tick();
      wb_clr_valid = 1'b1;
      wb_clr_idx   = 5'd9;
      tick();
      wb_clr_valid = 1'b0;
      @(negedge clk);
      chk("fl_sb_cleared", bus_if.in_ready, 1'b1);
      tick();
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk("fl_after_rd", bus_if.out_rd_idx, 5'd10);
      tick();
      tick();

      // ---- set and clear of x3 in the same cycle: set wins
      bus_if.instr_i  = enc_i(12'h000, 5'd2, 3'b010, 5'd3, OPC_LOAD);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      wb_clr_valid    = 1'b1;
      wb_clr_idx      = 5'd3;
      @(negedge clk);
      chk("sc_lw_valid", bus_if.out_valid, 1'b1);
      tick();
      wb_clr_valid    = 1'b0;
      bus_if.instr_i  = enc_i(12'h001, 5'd3, 3'b000, 5'd1, OPC_OP_IMM);
      bus_if.in_valid = 1'b1;
      @(negedge clk);
      chk("sc_set_wins", bus_if.in_ready, 1'b0);
      tick();
      wb_clr_valid = 1'b1;
      tick();
      wb_clr_valid = 1'b0;
      @(negedge clk);
      chk("sc_cleared", bus_if.in_ready, 1'b1);
      tick();
      bus_if.in_valid = 1'b0;
      tick();
      tick();

      // ---- load to x0 never creates a hazard
      bus_if.instr_i  = enc_i(12'h000, 5'd2, 3'b010, 5'd0, OPC_LOAD);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.instr_i = enc_i(12'h001, 5'd0, 3'b000, 5'd1, OPC_OP_IMM);
      @(negedge clk);
      chk("x0_ld_rd_en", bus_if.out_rd_en, 1'b0);
      chk("x0_no_match", bus_if.in_ready, 1'b1);
      tick();
      bus_if.in_valid = 1'b0;
      tick();
      tick();

      // ---- reset mid-operation drops bundle and scoreboard
      bus_if.instr_i  = enc_i(12'h000, 5'd2, 3'b010, 5'd12, OPC_LOAD);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      tick();
      bus_if.instr_i  = enc_i(12'h055, 5'd0, 3'b000, 5'd13, OPC_OP_IMM);
      bus_if.in_valid = 1'b1;
      tick();
      bus_if.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_valid", bus_if.out_valid, 1'b0);
      chk("mr_rd", bus_if.out_rd_idx, 5'd0);
      bus_if.instr_i = enc_r(7'b0000000, 5'd12, 5'd12, 3'b000, 5'd13, OPC_OP);
      #1;
      @(negedge clk);
      chk("mr_sb_clear", bus_if.in_ready, 1'b1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
